// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dp_ram_pkg;

    // Cross-port read-vs-write ordering on the same word
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word byte_merge handles; callers size-cast in and out
    localparam int MERGE_W = 256;
    localparam int MERGE_B = MERGE_W / 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Take new_w bytes where be is set, keep old_w bytes elsewhere
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_B-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_B; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Per-port read output pipeline: one or two register stages for data and valid.
// Data registers only load on a valid beat so the output holds between reads.
module dp_ram_rd_pipe #(
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic              vld1_q;
    logic [DATA_W-1:0] dat1_q;

    // First stage: capture the array word on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q <= 1'b0;
            dat1_q <= '0;
        end else begin
            vld1_q <= vld_i;
            if (vld_i) dat1_q <= data_i;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              vld2_q;
        logic [DATA_W-1:0] dat2_q;

        // Second stage: extra output register for timing
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld2_q <= 1'b0;
                dat2_q <= '0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) dat2_q <= dat1_q;
            end
        end

        assign rdata_o  = dat2_q;
        assign rvalid_o = vld2_q;
    end else begin : g_lat1
        assign rdata_o  = dat1_q;
        assign rvalid_o = vld1_q;
    end

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte enables, post-reset init sweep and
// same-address collision detection. Port A wins overlapping write bytes.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 7,
    parameter int              READ_LAT = 1,
    parameter int              RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                init_done,
    output logic                collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        return DATA_W'(byte_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_B'(be)));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              coll_q, coll_d;

    logic a_acc, b_acc, a_wr, b_wr, a_rd, b_rd, same_addr;
    logic [DATA_W-1:0] a_rword, b_rword;

    assign init_done = (state_q == READY);
    assign a_acc     = init_done & cs & a_en;
    assign b_acc     = init_done & cs & b_en;
    assign a_wr      = a_acc & a_we;
    assign b_wr      = b_acc & b_we;
    assign a_rd      = a_acc & ~a_we;
    assign b_rd      = b_acc & ~b_we;
    assign same_addr = (a_addr == b_addr);

    // Init FSM state and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one word per cycle, leave INIT after the last word is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = READY;
            end
            READY: ;
            default: state_d = INIT;
        endcase
    end

    // Array writes: init sweep, or merged port writes (A over B on shared bytes)
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= INIT_VAL;
        end else if (a_wr && b_wr && same_addr) begin
            mem_q[a_addr] <= be_merge(be_merge(mem_q[a_addr], b_wdata, b_be), a_wdata, a_be);
        end else begin
            if (a_wr) mem_q[a_addr] <= be_merge(mem_q[a_addr], a_wdata, a_be);
            if (b_wr) mem_q[b_addr] <= be_merge(mem_q[b_addr], b_wdata, b_be);
        end
    end

    // Read word; in write-first mode fold in the other port's same-word write
    always_comb begin
        a_rword = mem_q[a_addr];
        b_rword = mem_q[b_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && same_addr) begin
            if (b_wr) a_rword = be_merge(a_rword, b_wdata, b_be);
            if (a_wr) b_rword = be_merge(b_rword, a_wdata, a_be);
        end
    end

    // Collision: both ports hit one word and at least one is writing
    always_comb begin
        coll_d = a_acc & b_acc & same_addr & (a_we | b_we);
    end

    // Register the collision flag as a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll_q <= 1'b0;
        else     coll_q <= coll_d;
    end

    assign collision = coll_q;

    dp_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rd_a (
        .clk      (clk),
        .rst      (rst),
        .vld_i    (a_rd),
        .data_i   (a_rword),
        .rdata_o  (a_rdata),
        .rvalid_o (a_rvalid)
    );

    dp_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rd_b (
        .clk      (clk),
        .rst      (rst),
        .vld_i    (b_rd),
        .data_i   (b_rword),
        .rdata_o  (b_rdata),
        .rvalid_o (b_rvalid)
    );

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench: two instances (lat1/read-first, lat2/write-first) share
// stimulus; a behavioural memory model predicts every read beat and collision.
module tb_dp_ram_be;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b0;
    logic a_en = 0, a_we = 0, b_en = 0, b_we = 0;
    logic [1:0] a_be = 0, b_be = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [DW-1:0] a_wdata = 0, b_wdata = 0;

    logic [DW-1:0] ard0, brd0, ard1, brd1;
    logic arv0, brv0, arv1, brv1, idn0, idn1, col0, col1;

    always #5 clk = ~clk;

    dp_ram_be #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .cs(cs),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(ard0), .a_rvalid(arv0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(brd0), .b_rvalid(brv0),
        .init_done(idn0), .collision(col0)
    );

    dp_ram_be #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .cs(cs),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(ard1), .a_rvalid(arv1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(brd1), .b_rvalid(brv1),
        .init_done(idn1), .collision(col1)
    );

    typedef struct {
        bit            en;
        bit            we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    // streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
    exp_t  q[4][$];
    int    lat[4] = '{1, 1, 2, 2};
    string pn[4]  = '{"a0", "b0", "a1", "b1"};
    logic [DW-1:0] mem_m [DEPTH];
    bit    exp_coll[int];
    int    cyc = 0, rel_cyc = 0;
    int    n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            if (q[p].size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL %s_rvalid: got unexpected beat data %0h (cycle %0d)", pn[p], d, cyc);
            end else begin
                e = q[p].pop_front();
                chk({pn[p], "_rdata"}, d, e.d);
                chk({pn[p], "_cycle"}, cyc, e.c);
            end
        end else if (q[p].size() > 0 && q[p][0].c <= cyc) begin
            e = q[p].pop_front();
            n_chk++; n_err++;
            $display("FAIL %s_rvalid: got 0 expected beat %0h due cycle %0d", pn[p], e.d, e.c);
        end
    endtask

    // Monitor: every falling edge compare outputs against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_a_rdata0", ard0, 0);  chk("rst_b_rdata1", brd1, 0);
            chk("rst_rvalid0", {arv0, brv0}, 0);
            chk("rst_rvalid1", {arv1, brv1}, 0);
            chk("rst_init_done", {idn0, idn1}, 0);
            chk("rst_collision", {col0, col1}, 0);
        end else begin
            mon_port(0, arv0, ard0);
            mon_port(1, brv0, brd0);
            mon_port(2, arv1, ard1);
            mon_port(3, brv1, brd1);
            chk("collision0", col0, exp_coll.exists(cyc) ? 1 : 0);
            chk("collision1", col1, exp_coll.exists(cyc) ? 1 : 0);
            chk("init_done0", idn0, (cyc - rel_cyc) >= DEPTH ? 1 : 0);
            chk("init_done1", idn1, (cyc - rel_cyc) >= DEPTH ? 1 : 0);
        end
    end

    function automatic req_t idle();
        req_t r = '{0, 0, 2'b00, '0, '0};
        return r;
    endfunction

    function automatic req_t rd(input int addr);
        req_t r = '{1, 0, 2'b00, AW'(addr), '0};
        return r;
    endfunction

    function automatic req_t wr(input int addr, input logic [DW-1:0] d, input logic [1:0] be);
        req_t r = '{1, 1, be, AW'(addr), d};
        return r;
    endfunction

    function automatic req_t rnd();
        req_t r;
        r.en   = ($urandom_range(0, 3) != 0);
        r.we   = $urandom_range(0, 1);
        r.be   = 2'($urandom_range(0, 3));
        r.addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                             : AW'($urandom_range(0, 7));
        r.wd   = DW'($urandom);
        return r;
    endfunction

    // Overlay bytes of w where be is set
    function automatic logic [DW-1:0] overlay(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                              input logic [1:0] be);
        logic [DW-1:0] r = o;
        if (be[0]) r[7:0]  = w[7:0];
        if (be[1]) r[15:8] = w[15:8];
        return r;
    endfunction

    // One cycle of stimulus: predict responses from the model, then advance it
    task automatic op(input req_t a, input req_t b, input bit cs_);
        bit ready, aacc, bacc, same;
        logic [DW-1:0] d;
        exp_t e;
        cs = cs_;
        a_en = a.en; a_we = a.we; a_be = a.be; a_addr = a.addr; a_wdata = a.wd;
        b_en = b.en; b_we = b.we; b_be = b.be; b_addr = b.addr; b_wdata = b.wd;
        ready = (cyc - rel_cyc) >= DEPTH;
        aacc  = ready && cs_ && a.en;
        bacc  = ready && cs_ && b.en;
        same  = (a.addr == b.addr);
        for (int k = 0; k < 2; k++) begin
            if (aacc && !a.we) begin
                d = mem_m[a.addr];
                if (k == 1 && bacc && b.we && same) d = overlay(d, b.wd, b.be);
                e.d = d; e.c = cyc + lat[2*k]; q[2*k].push_back(e);
            end
            if (bacc && !b.we) begin
                d = mem_m[b.addr];
                if (k == 1 && aacc && a.we && same) d = overlay(d, a.wd, a.be);
                e.d = d; e.c = cyc + lat[2*k+1]; q[2*k+1].push_back(e);
            end
        end
        if (aacc && bacc && same && (a.we || b.we)) exp_coll[cyc + 1] = 1'b1;
        if (aacc && a.we) mem_m[a.addr] = overlay(mem_m[a.addr], a.wd, a.be);
        if (bacc && b.we)
            mem_m[b.addr] = overlay(mem_m[b.addr], b.wd,
                                    (aacc && a.we && same) ? (b.be & ~a.be) : b.be);
        @(negedge clk);
    endtask

    task automatic rst_assert();
        #1 rst = 1'b1;
        cs = 0; a_en = 0; b_en = 0; a_we = 0; b_we = 0;
        for (int p = 0; p < 4; p++) q[p].delete();
        exp_coll.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic rst_release(input int hold);
        repeat (hold) @(negedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        while (!idn0 && n < DEPTH + 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_init_cycles"}, n, DEPTH);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rst_release(3);
        wait_init("first");

        // init value at top address
        op(rd(127), idle(), 1);
        // byte enables
        op(wr(5, 16'hABCD, 2'b11), idle(), 1);
        op(wr(5, 16'h1234, 2'b01), idle(), 1);
        op(rd(5), idle(), 1);
        // both ports write the same word
        op(wr(9, 16'h1111, 2'b10), wr(9, 16'h2222, 2'b11), 1);
        op(rd(9), rd(9), 1);
        // cross-port write vs read on one word
        op(wr(3, 16'h00FF, 2'b11), idle(), 1);
        op(wr(3, 16'h5A5A, 2'b11), rd(3), 1);
        op(idle(), rd(3), 1);
        // streaming reads on B, plus a cs=0 cycle that must be ignored
        for (int i = 0; i < 4; i++) op(idle(), rd(i), 1);
        op(wr(4, 16'hFFFF, 2'b11), rd(4), 0);
        op(rd(4), idle(), 1);
        repeat (3) op(idle(), idle(), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) op(rnd(), rnd(), $urandom_range(0, 7) != 0);
        repeat (3) op(idle(), idle(), 1);

        // reset while a two-stage read is in flight
        op(idle(), rd(2), 1);
        rst_assert();
        rst_release(2);
        repeat (50) @(negedge clk);
        // reset again halfway through the sweep
        rst_assert();
        rst_release(2);
        wait_init("restart");

        // memory is back to the init value
        op(rd(5), rd(9), 1);
        op(rd(3), rd(3), 1);
        for (int i = 0; i < 150; i++) op(rnd(), rnd(), $urandom_range(0, 7) != 0);
        repeat (4) op(idle(), idle(), 1);
        for (int p = 0; p < 4; p++) chk({pn[p], "_drain"}, q[p].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #400000;
        $display("FAIL timeout: got no completion expected finish by 400000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dp_ram_be.md
Name: dp_ram_be

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables and a configurable read latency (1 or 2).
- Selectable same-port read-during-write mode; deterministic cross-port collision resolution plus a collision flag.
- Memory is cleared by a sequential init sweep after reset; there is no single-cycle bulk clear.
- Shared scratch/buffer memory for datapath blocks that need two independent access ports.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- cs  in  1  chip select; gates both ports.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  DATA_W/8  port A byte enables; ignored on reads.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  port A read data valid, one-cycle pulse per read.
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: same as the port A signals, for port B.
- init_done  out  1  high once the init sweep completes; requests are accepted only while high.
- collision  out  1  one-cycle pulse on a same-address cross-port conflict.

Behaviour:
- Reset (async): a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, init_done = 0, collision = 0.
  - Init FSM enters INIT with the sweep counter at 0.
  - Asserting rst mid-operation aborts any sweep or in-flight read; pipeline valids clear and the sweep restarts at 0.
- Init FSM states:
  - INIT: writes INIT_VAL to word cnt each cycle, cnt++. When cnt == DEPTH-1 is written, next state is READY. INIT takes exactly DEPTH cycles after rst deasserts.
  - READY: init_done = 1. Stays in READY until rst.
  - During INIT, all port requests are ignored: no writes, no rvalid.
- Accept condition per port: init_done & cs & x_en.
- Write: on the accept edge, each byte i with x_be[i] = 1 is updated; bytes with x_be[i] = 0 are untouched. be = 0 is a legal no-op write. No rvalid is generated for writes.
- Read:
  - READ_LAT=1: x_rdata updates and x_rvalid pulses on the cycle after accept.
  - READ_LAT=2: an extra output register stage is added; data and valid appear 2 cycles after accept.
  - x_rdata holds its last value while x_rvalid = 0.
- Back-to-back reads are accepted every cycle; throughput is 1 access per port per cycle.
- Same-port read-during-write (x_we=1 with a read of the same word): this is N/A, since a port is either read or write per cycle. RDW_MODE instead governs cross-port read vs. write on the same address:
  - 0: the reader gets the pre-write word.
  - 1: the reader gets the post-write merged word.
- Cross-port, same address, both accepted:
  - Both writes: per byte, A wins where a_be = 1. Bytes enabled only in b_be take B data. collision pulses next cycle.
  - One write, one read: read data per RDW_MODE; collision pulses next cycle.
  - Both reads: both get identical data; no collision.
- Different addresses: ports are fully independent.
- cs = 0: no accepts. Reads already in flight in the 2-stage pipeline still complete.
- Address wrap: none. All ADDR_W values are legal.

Decomposition:
- Package dp_ram_pkg holds:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1.
  - Init FSM state enum {INIT, READY}.
  - Function byte_merge(old, new, be) for byte-enable merging.
- Sub-module dp_ram_rd_pipe (params DATA_W, READ_LAT) implements the per-port read data/valid output pipeline; it is instantiated twice.
- Init FSM, storage array and collision logic live in the top module.

Test Plan:
- Init sweep: with default params, release rst → init_done rises exactly 128 cycles later. A read of addr 0x7F then returns 0x0000 with a_rvalid one cycle after accept.
- Byte enables: write A addr 5 0xABCD be=11, then addr 5 0x1234 be=01 → a read of addr 5 returns 0xAB34.
- Collision, both writes: same cycle, A writes addr 9 0x1111 be=10 and B writes addr 9 0x2222 be=11 → addr 9 = 0x1122 and collision pulses once.
- Cross read/write: addr 3 holds 0x00FF; A writes 0x5A5A while B reads addr 3. With RDW_MODE=0, b_rdata = 0x00FF; with RDW_MODE=1, b_rdata = 0x5A5A. collision pulses in both cases.
- Latency and streaming: READ_LAT=2, B reads addrs 0..3 on consecutive cycles → b_rvalid is high for 4 cycles starting 2 cycles after the first accept, with data in order.
- Reset mid-operation: assert rst during a READ_LAT=2 read and during INIT at cnt = 50 → rvalid never pulses, init_done = 0, and the sweep restarts and takes a full 128 cycles.
